// File: rtl/cereal_rx.sv
// Serial byte receiver (start/8N/stop, LSB first) feeding a 4-entry FIFO on a valid/ready port.
// Byte visible one cycle after the stop sample; a full FIFO drops the byte and sets sticky overflow.
module cereal_rx #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       sysclk,
    input  logic       reset,
    input  logic       serialIn,
    input  logic       rd_ready,
    output logic [7:0] data,
    output logic       valid,
    output logic [2:0] count,
    output logic       busy,
    output logic       frame_err,
    output logic       overflow
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_BREAK} state_t;

    state_t          state, state_nx;
    logic            rx_m, rx_s;
    logic [CW-1:0]   cnt;
    logic [2:0]      idx;
    logic [7:0]      shift;
    logic            tick, push, ferr_d, busy_d;

    logic [7:0]      mem [4];
    logic [1:0]      rptr, wptr, rptr_nx;
    logic [2:0]      count_nx;
    logic            pop, push_ok;

    always_ff @(posedge sysclk) begin
        if (reset) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
        end else begin
            rx_m <= serialIn;
            rx_s <= rx_m;
        end
    end

    assign tick = (cnt == '0);

    always_ff @(posedge sysclk) begin
        if (reset) state <= S_BREAK;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (!rx_s) state_nx = S_START;
            S_START: if (tick) state_nx = rx_s ? S_IDLE : S_DATA;
            S_DATA:  if (tick && idx == 3'd7) state_nx = S_STOP;
            S_STOP:  if (tick) state_nx = rx_s ? S_IDLE : S_BREAK;
            S_BREAK: if (rx_s) state_nx = S_IDLE;
            default: state_nx = S_BREAK;
        endcase
    end

    always_comb begin
        push   = (state == S_STOP) && tick && rx_s;
        ferr_d = (state == S_STOP) && tick && !rx_s;
        busy_d = (state_nx != S_IDLE);
    end

    // Counter reloads on every state entry and at each bit boundary inside DATA.
    always_ff @(posedge sysclk) begin
        if (reset) begin
            cnt       <= '0;
            idx       <= '0;
            shift     <= '0;
            frame_err <= 1'b0;
            busy      <= 1'b0;
        end else begin
            frame_err <= ferr_d;
            busy      <= busy_d;
            if (state_nx != state || tick)
                cnt <= (state_nx == S_START) ? HALF : FULL;
            else
                cnt <= cnt - 1'b1;
            if (state != S_DATA)
                idx <= '0;
            else if (tick) begin
                idx        <= idx + 1'b1;
                shift[idx] <= rx_s;
            end
        end
    end

    assign pop     = valid && rd_ready;
    assign push_ok = push && (count != 3'd4 || pop);
    assign rptr_nx = pop ? rptr + 1'b1 : rptr;

    always_comb begin
        case ({push_ok, pop})
            2'b10:   count_nx = count + 3'd1;
            2'b01:   count_nx = count - 3'd1;
            default: count_nx = count;
        endcase
    end

    // Head register bypasses the array when the new head is the byte being written now.
    always_ff @(posedge sysclk) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) mem[i] <= '0;
            rptr     <= '0;
            wptr     <= '0;
            count    <= '0;
            valid    <= 1'b0;
            data     <= '0;
            overflow <= 1'b0;
        end else begin
            if (push_ok) begin
                mem[wptr] <= shift;
                wptr      <= wptr + 1'b1;
            end
            rptr  <= rptr_nx;
            count <= count_nx;
            valid <= (count_nx != 3'd0);
            data  <= (push_ok && rptr_nx == wptr) ? shift : mem[rptr_nx];
            if (push && !push_ok) overflow <= 1'b1;
        end
    end
endmodule

// File: tb/tb_cereal_rx.sv
// Directed bench for cereal_rx at 16 clocks per bit.
module tb_cereal_rx;
    localparam int C = 16;

    logic       sysclk = 1'b0;
    logic       reset = 1'b1;
    logic       serialIn = 1'b1;
    logic       rd_ready = 1'b0;
    logic [7:0] data;
    logic       valid;
    logic [2:0] count;
    logic       busy;
    logic       frame_err;
    logic       overflow;

    int errors = 0;
    int checks = 0;
    int fe_cnt = 0;
    int fe0;

    cereal_rx #(.CLKS_PER_BIT(C)) dut (
        .sysclk(sysclk), .reset(reset), .serialIn(serialIn), .rd_ready(rd_ready),
        .data(data), .valid(valid), .count(count), .busy(busy),
        .frame_err(frame_err), .overflow(overflow)
    );

    always #5 sysclk = ~sysclk;

    always @(posedge sysclk) if (frame_err === 1'b1) fe_cnt <= fe_cnt + 1;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called #1 after an edge; returns #1 after the edge that ends data bit 7.
    task automatic drive_bits(input logic [7:0] b);
        serialIn = 1'b0;
        repeat (C) @(posedge sysclk);
        #1;
        for (int i = 0; i < 8; i++) begin
            serialIn = b[i];
            repeat (C) @(posedge sysclk);
            #1;
        end
    endtask

    task automatic send_frame(input logic [7:0] b);
        drive_bits(b);
        serialIn = 1'b1;
        repeat (C) @(posedge sysclk);
        #1;
    endtask

    task automatic pop_check(input string tag, input logic [7:0] exp);
        check({tag, "_valid"}, 8'(valid), 8'd1);
        check(tag, data, exp);
        rd_ready = 1'b1;
        @(posedge sysclk);
        #1;
        rd_ready = 1'b0;
    endtask

    initial begin
        logic [7:0] b;

        repeat (3) @(posedge sysclk);
        #1;
        check("rst_data", data, 8'h00);
        check("rst_valid", 8'(valid), 8'd0);
        check("rst_count", 8'(count), 8'd0);
        check("rst_busy", 8'(busy), 8'd0);
        check("rst_ferr", 8'(frame_err), 8'd0);
        check("rst_ovf", 8'(overflow), 8'd0);
        reset = 1'b0;
        repeat (5) @(posedge sysclk);
        #1;
        check("idle_busy", 8'(busy), 8'd0);

        // Single byte: valid must rise exactly one cycle after the stop sample.
        drive_bits(8'hA5);
        check("t1_busy", 8'(busy), 8'd1);
        serialIn = 1'b1;
        repeat (10) @(posedge sysclk);
        #1;
        check("t1_valid_early", 8'(valid), 8'd0);
        @(posedge sysclk);
        #1;
        check("t1_valid", 8'(valid), 8'd1);
        check("t1_data", data, 8'hA5);
        check("t1_count", 8'(count), 8'd1);
        repeat (5) @(posedge sysclk);
        #1;
        rd_ready = 1'b1;
        @(posedge sysclk);
        #1;
        rd_ready = 1'b0;
        check("t1_pop_valid", 8'(valid), 8'd0);
        check("t1_pop_count", 8'(count), 8'd0);
        check("t1_busy_end", 8'(busy), 8'd0);

        // Back-to-back frames fill the FIFO exactly.
        send_frame(8'h00);
        send_frame(8'hFF);
        send_frame(8'h3C);
        send_frame(8'hC3);
        check("t2_count", 8'(count), 8'd4);
        check("t2_ovf", 8'(overflow), 8'd0);
        pop_check("t2_pop0", 8'h00);
        pop_check("t2_pop1", 8'hFF);
        pop_check("t2_pop2", 8'h3C);
        pop_check("t2_pop3", 8'hC3);
        check("t2_empty", 8'(valid), 8'd0);

        // Push and pop in the same cycle while full.
        send_frame(8'h01);
        send_frame(8'h02);
        send_frame(8'h03);
        send_frame(8'h04);
        drive_bits(8'h05);
        serialIn = 1'b1;
        repeat (10) @(posedge sysclk);
        #1;
        rd_ready = 1'b1;
        @(posedge sysclk);
        #1;
        rd_ready = 1'b0;
        check("t3_count", 8'(count), 8'd4);
        check("t3_ovf", 8'(overflow), 8'd0);
        check("t3_head", data, 8'h02);
        repeat (5) @(posedge sysclk);
        #1;
        pop_check("t3_pop0", 8'h02);
        pop_check("t3_pop1", 8'h03);
        pop_check("t3_pop2", 8'h04);
        pop_check("t3_pop3", 8'h05);
        check("t3_empty", 8'(count), 8'd0);

        // Overflow: fifth byte is dropped.
        for (int i = 1; i <= 5; i++) send_frame(8'(i));
        check("t4_count", 8'(count), 8'd4);
        check("t4_ovf", 8'(overflow), 8'd1);
        pop_check("t4_pop0", 8'h01);
        pop_check("t4_pop1", 8'h02);
        pop_check("t4_pop2", 8'h03);
        pop_check("t4_pop3", 8'h04);
        check("t4_empty", 8'(valid), 8'd0);

        // Bad stop bit followed by a long low line.
        fe0 = fe_cnt;
        drive_bits(8'h55);
        serialIn = 1'b0;
        repeat (10) @(posedge sysclk);
        #1;
        check("t5_ferr_early", 8'(frame_err), 8'd0);
        @(posedge sysclk);
        #1;
        check("t5_ferr", 8'(frame_err), 8'd1);
        check("t5_count", 8'(count), 8'd0);
        @(posedge sysclk);
        #1;
        check("t5_ferr_end", 8'(frame_err), 8'd0);
        repeat (44) @(posedge sysclk);
        #1;
        serialIn = 1'b1;
        repeat (40) @(posedge sysclk);
        #1;
        check("t5_ferr_pulses", 8'(fe_cnt - fe0), 8'd1);
        check("t5_valid", 8'(valid), 8'd0);
        check("t5_busy", 8'(busy), 8'd0);

        // Three-cycle start glitch.
        serialIn = 1'b0;
        repeat (3) @(posedge sysclk);
        #1;
        serialIn = 1'b1;
        repeat (2) @(posedge sysclk);
        #1;
        check("t6_busy", 8'(busy), 8'd1);
        repeat (15) @(posedge sysclk);
        #1;
        check("t6_busy_end", 8'(busy), 8'd0);
        check("t6_count", 8'(count), 8'd0);
        check("t6_ferr_pulses", 8'(fe_cnt - fe0), 8'd1);

        // Reset in the middle of data bit 4 with two bytes buffered.
        send_frame(8'h11);
        send_frame(8'h22);
        check("t7_count", 8'(count), 8'd2);
        b = 8'h5A;
        serialIn = 1'b0;
        repeat (C) @(posedge sysclk);
        #1;
        for (int i = 0; i < 4; i++) begin
            serialIn = b[i];
            repeat (C) @(posedge sysclk);
            #1;
        end
        serialIn = b[4];
        repeat (8) @(posedge sysclk);
        #1;
        reset = 1'b1;
        @(posedge sysclk);
        #1;
        check("t7_data", data, 8'h00);
        check("t7_valid", 8'(valid), 8'd0);
        check("t7_count0", 8'(count), 8'd0);
        check("t7_busy", 8'(busy), 8'd0);
        check("t7_ferr", 8'(frame_err), 8'd0);
        check("t7_ovf", 8'(overflow), 8'd0);
        repeat (7) @(posedge sysclk);
        #1;
        for (int i = 5; i < 8; i++) begin
            serialIn = b[i];
            repeat (C) @(posedge sysclk);
            #1;
        end
        serialIn = 1'b1;
        repeat (C) @(posedge sysclk);
        #1;
        reset = 1'b0;
        repeat (20) @(posedge sysclk);
        #1;
        check("t7_idle_valid", 8'(valid), 8'd0);
        check("t7_idle_busy", 8'(busy), 8'd0);
        send_frame(8'h81);
        check("t7_count1", 8'(count), 8'd1);
        pop_check("t7_pop", 8'h81);
        check("t7_empty", 8'(valid), 8'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
